// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I core: shadows the EX/MEM destinations,
// registers EX operand forwarding selects, and sequences load-use/mem-wait/redirect stalls.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_reg_wen,
  input  logic             i_id_mem_read,
  input  logic             i_ex_redirect,
  input  logic             i_mem_valid,
  input  logic             i_mem_ready,
  output logic             o_frwd_alu_op1,
  output logic             o_frwd_mem_alu_op1,
  output logic             o_frwd_mem_op1,
  output logic             o_frwd_alu_op2,
  output logic             o_frwd_mem_alu_op2,
  output logic             o_frwd_mem_op2,
  output logic             o_stall_fd,
  output logic             o_stall_all,
  output logic             o_flush_fd,
  output logic             o_bubble_ex,
  output logic [CNT_W-1:0] o_lu_cnt
);

  // e1 shadows the instruction in EX, e2 the one in MEM
  logic       e1_valid, e1_wen, e1_load;
  logic [4:0] e1_rd;
  logic       e2_valid, e2_wen, e2_load;
  logic [4:0] e2_rd;

  logic       mw, lu, lu_taken;
  logic [2:0] fwd1, fwd2;

  function automatic logic writes(input logic v, input logic w, input logic [4:0] rd,
                                  input logic [4:0] r);
    return v & w & (rd == r) & (r != 5'd0);
  endfunction

  // returns {alu, mem_alu, mem}; nearest producer wins
  function automatic logic [2:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input logic e1v, input logic e1w, input logic [4:0] e1r,
                                         input logic e2v, input logic e2w, input logic [4:0] e2r,
                                         input logic e2l);
    logic [2:0] sel;
    sel = 3'b000;
    if (use_r) begin
      if (writes(e1v, e1w, e1r, r))
        sel = 3'b100;
      else if (writes(e2v, e2w, e2r, r) && !e2l)
        sel = 3'b010;
      else if (writes(e2v, e2w, e2r, r))
        sel = 3'b001;
    end
    return sel;
  endfunction

  always_comb begin
    mw = i_mem_valid & ~i_mem_ready;
    lu = i_id_valid & e1_valid & e1_load & e1_wen & (e1_rd != 5'd0) &
         ((i_id_use_rs1 & (i_id_rs1 == e1_rd)) | (i_id_use_rs2 & (i_id_rs2 == e1_rd)));
    o_stall_fd  = 1'b0;
    o_stall_all = 1'b0;
    o_flush_fd  = 1'b0;
    o_bubble_ex = 1'b0;
    lu_taken    = 1'b0;
    if (mw) begin
      o_stall_all = 1'b1;
    end else if (i_ex_redirect) begin
      o_flush_fd  = 1'b1;
      o_bubble_ex = 1'b1;
    end else if (lu) begin
      o_stall_fd  = 1'b1;
      o_bubble_ex = 1'b1;
      lu_taken    = 1'b1;
    end
    fwd1 = fwd_sel(i_id_use_rs1, i_id_rs1, e1_valid, e1_wen, e1_rd,
                   e2_valid, e2_wen, e2_rd, e2_load);
    fwd2 = fwd_sel(i_id_use_rs2, i_id_rs2, e1_valid, e1_wen, e1_rd,
                   e2_valid, e2_wen, e2_rd, e2_load);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      e1_valid <= 1'b0;
      e1_wen   <= 1'b0;
      e1_load  <= 1'b0;
      e1_rd    <= 5'd0;
      e2_valid <= 1'b0;
      e2_wen   <= 1'b0;
      e2_load  <= 1'b0;
      e2_rd    <= 5'd0;
      {o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1} <= 3'b000;
      {o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2} <= 3'b000;
      o_lu_cnt <= '0;
    end else if (!mw) begin
      e2_valid <= e1_valid;
      e2_wen   <= e1_wen;
      e2_load  <= e1_load;
      e2_rd    <= e1_rd;
      e1_valid <= i_id_valid & ~o_bubble_ex;
      e1_wen   <= i_id_reg_wen;
      e1_load  <= i_id_mem_read;
      e1_rd    <= i_id_rd;
      {o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1} <= o_bubble_ex ? 3'b000 : fwd1;
      {o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2} <= o_bubble_ex ? 3'b000 : fwd2;
      if (lu_taken && (o_lu_cnt != {CNT_W{1'b1}}))
        o_lu_cnt <= o_lu_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: drives short instruction sequences through ID and
// compares stall controls and registered forwarding selects with hand-computed values.
module tb_hazard_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_id_valid;
  logic [4:0]  i_id_rs1, i_id_rs2, i_id_rd;
  logic        i_id_use_rs1, i_id_use_rs2, i_id_reg_wen, i_id_mem_read;
  logic        i_ex_redirect, i_mem_valid, i_mem_ready;
  logic        o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1;
  logic        o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2;
  logic        o_stall_fd, o_stall_all, o_flush_fd, o_bubble_ex;
  logic [15:0] o_lu_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  hazard_ctrl #(.CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_id_valid(i_id_valid),
    .i_id_rs1(i_id_rs1), .i_id_rs2(i_id_rs2),
    .i_id_use_rs1(i_id_use_rs1), .i_id_use_rs2(i_id_use_rs2),
    .i_id_rd(i_id_rd), .i_id_reg_wen(i_id_reg_wen), .i_id_mem_read(i_id_mem_read),
    .i_ex_redirect(i_ex_redirect), .i_mem_valid(i_mem_valid), .i_mem_ready(i_mem_ready),
    .o_frwd_alu_op1(o_frwd_alu_op1), .o_frwd_mem_alu_op1(o_frwd_mem_alu_op1),
    .o_frwd_mem_op1(o_frwd_mem_op1), .o_frwd_alu_op2(o_frwd_alu_op2),
    .o_frwd_mem_alu_op2(o_frwd_mem_alu_op2), .o_frwd_mem_op2(o_frwd_mem_op2),
    .o_stall_fd(o_stall_fd), .o_stall_all(o_stall_all), .o_flush_fd(o_flush_fd),
    .o_bubble_ex(o_bubble_ex), .o_lu_cnt(o_lu_cnt)
  );

  always #5 i_clk = ~i_clk;

  // {alu1, mem_alu1, mem1, alu2, mem_alu2, mem2}
  wire [5:0] sel = {o_frwd_alu_op1, o_frwd_mem_alu_op1, o_frwd_mem_op1,
                    o_frwd_alu_op2, o_frwd_mem_alu_op2, o_frwd_mem_op2};
  // {stall_fd, stall_all, flush_fd, bubble_ex}
  wire [3:0] ctl = {o_stall_fd, o_stall_all, o_flush_fd, o_bubble_ex};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic id(input logic v, input logic [4:0] rs1, input logic u1,
                    input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                    input logic wen, input logic ld);
    i_id_valid = v; i_id_rs1 = rs1; i_id_use_rs1 = u1; i_id_rs2 = rs2;
    i_id_use_rs2 = u2; i_id_rd = rd; i_id_reg_wen = wen; i_id_mem_read = ld;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic nops(input int n);
    i_ex_redirect = 1'b0; i_mem_valid = 1'b0; i_mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_ex_redirect = 1'b0; i_mem_valid = 1'b0; i_mem_ready = 1'b1;
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick(); tick();
    i_rst_n = 1'b1;
    #1;
    chk("rst_sel", sel, 6'b0);
    chk("rst_cnt", o_lu_cnt, 16'd0);
    chk("rst_ctl", ctl, 4'b0);

    // add x5,x1,x2 ; sub x6,x5,x7
    id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("alu_ctl", ctl, 4'b0000);
    tick();
    chk("alu_fwd_op1", sel, 6'b100000);

    // lw x5 ; add x6,x7,x5 -> one bubble then mem forward on op2
    nops(2);
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    chk("lu_ctl", ctl, 4'b1001);
    tick();
    chk("lu_bubble_sel", sel, 6'b0);
    chk("lu_cnt1", o_lu_cnt, 16'd1);
    chk("lu_after_ctl", ctl, 4'b0000);
    tick();
    chk("lu_mem_op2", sel, 6'b000001);
    chk("lu_cnt_hold", o_lu_cnt, 16'd1);

    // x0 never forwards or stalls
    nops(2);
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    chk("x0_ctl", ctl, 4'b0000);
    tick();
    chk("x0_sel", sel, 6'b0);
    nops(2);
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0);
    chk("x0_load_ctl", ctl, 4'b0000);

    // two producers of x5: nearest wins
    nops(2);
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    tick();
    chk("dist12_sel", sel, 6'b100000);

    // distance-2 ALU producer on op2
    nops(2);
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    id(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    chk("dist2_sel", sel, 6'b000010);

    // mem wait for 3 cycles over a pending load-use
    nops(2);
    id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    chk("mw_pre_sel", sel, 6'b100000);
    id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    i_mem_valid = 1'b1; i_mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mw_ctl%0d", i), ctl, 4'b0100);
      tick();
      chk($sformatf("mw_sel%0d", i), sel, 6'b100000);
      chk($sformatf("mw_cnt%0d", i), o_lu_cnt, 16'd1);
    end
    i_mem_valid = 1'b0; i_mem_ready = 1'b1;
    #1;
    chk("mw_release_ctl", ctl, 4'b1001);
    tick();
    chk("mw_release_cnt", o_lu_cnt, 16'd2);
    chk("mw_release_sel", sel, 6'b0);
    tick();
    chk("mw_mem_op1", sel, 6'b001000);

    // redirect beats load-use
    nops(2);
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    i_ex_redirect = 1'b1;
    #1;
    chk("redir_ctl", ctl, 4'b0011);
    tick();
    chk("redir_cnt", o_lu_cnt, 16'd2);
    chk("redir_sel", sel, 6'b0);
    i_ex_redirect = 1'b0;

    // reset during a mem-wait stall
    nops(2);
    id(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    tick();
    id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
    tick();
    id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    i_mem_valid = 1'b1; i_mem_ready = 1'b0;
    tick();
    chk("prerst_sel", sel, 6'b100000);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1; i_mem_valid = 1'b0; i_mem_ready = 1'b1;
    #1;
    chk("midrst_sel", sel, 6'b0);
    chk("midrst_cnt", o_lu_cnt, 16'd0);
    chk("midrst_ctl", ctl, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
